// File: rtl/bnn_mem_responder_pkg.sv
// Shared constants, state encoding and sizing defaults for the fetch-port memory responder.
package bnn_mem_responder_pkg;

    // Command encodings on the rw bus
    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;
    localparam logic [1:0] RW_CLEAR = 2'b11;

    // Responder sequencing states
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Default sizing for the x-port and w-port instances
    localparam int unsigned DEF_SEL_LEN   = 2;
    localparam int unsigned DEF_NUM_BANKS = 1 << DEF_SEL_LEN;
    localparam int unsigned DEPTH_X       = 784;
    localparam int unsigned DEPTH_W       = 802816 / DEF_NUM_BANKS;

    // Index width needed to address 'depth' words (at least 1 bit)
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bnn_mem_bank.sv
// One bank: DEPTH x DATA_LEN array, synchronous write, registered read holding its last value.
module bnn_mem_bank #(
    parameter int unsigned DATA_LEN = 1,
    parameter int unsigned DEPTH    = 784,
    parameter int unsigned IDX_W    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    output logic [DATA_LEN-1:0] rdata_o
);

    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic [DATA_LEN-1:0] rdata_q;

    // Array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register only updates on an accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bnn_mem_responder.sv
// Memory-side responder: banked single-word read/write with post-reset init and bank-clear sweeps.
module bnn_mem_responder
    import bnn_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 10,
    parameter int unsigned DATA_LEN = 1,
    parameter int unsigned SEL_LEN  = 2,
    parameter int unsigned RW_LEN   = 2,
    parameter int unsigned DEPTH    = DEPTH_X
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [SEL_LEN-1:0]  sel,
    input  logic [RW_LEN-1:0]   rw,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata,
    output logic                rvalid,
    output logic                busy,
    output logic                err
);

    localparam int unsigned NUM_BANKS = 1 << SEL_LEN;
    localparam int unsigned IDX_W     = idx_width(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] ptr_q, ptr_d;
    logic [SEL_LEN-1:0]  clr_bank_q, clr_bank_d;
    logic [SEL_LEN-1:0]  sel_q, sel_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [NUM_BANKS-1:0] bank_we_c;
    logic [NUM_BANKS-1:0] bank_re_c;
    logic [IDX_W-1:0]     mem_idx_c;
    logic [DATA_LEN-1:0]  mem_wdata_c;
    logic                 addr_ok_c;
    logic                 ptr_last_c;
    logic [DATA_LEN-1:0]  bank_rdata [NUM_BANKS];

    assign addr_ok_c  = (32'(addr) < DEPTH);
    assign ptr_last_c = (ptr_q == ADDR_LEN'(DEPTH - 1));

    // State, sweep pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            clr_bank_q <= '0;
            sel_q      <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_bank_q <= clr_bank_d;
            sel_q      <= sel_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, command decode and bank strobes
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clr_bank_d  = clr_bank_q;
        sel_d       = sel_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        bank_we_c   = '0;
        bank_re_c   = '0;
        mem_idx_c   = addr[IDX_W-1:0];
        mem_wdata_c = wdata;

        case (state_q)
            ST_INIT, ST_CLEAR: begin
                // Sweep zeros through every bank (INIT) or the captured bank (CLEAR)
                mem_idx_c   = ptr_q[IDX_W-1:0];
                mem_wdata_c = '0;
                if (state_q == ST_INIT) begin
                    bank_we_c = '1;
                end else begin
                    bank_we_c[clr_bank_q] = 1'b1;
                end
                if (rw != RW_LEN'(RW_IDLE)) begin
                    err_d = 1'b1;
                end
                if (ptr_last_c) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_LEN'(1);
                end
            end

            ST_IDLE: begin
                case (rw)
                    RW_LEN'(RW_READ): begin
                        if (addr_ok_c) begin
                            bank_re_c[sel] = 1'b1;
                            sel_d          = sel;
                            rvalid_d       = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    RW_LEN'(RW_WRITE): begin
                        if (addr_ok_c) begin
                            bank_we_c[sel] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    RW_LEN'(RW_CLEAR): begin
                        state_d    = ST_CLEAR;
                        clr_bank_d = sel;
                        ptr_d      = '0;
                    end
                    default: begin
                    end
                endcase
            end

            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Bank array
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bnn_mem_bank #(
            .DATA_LEN(DATA_LEN),
            .DEPTH   (DEPTH),
            .IDX_W   (IDX_W)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we_i   (bank_we_c[b]),
            .re_i   (bank_re_c[b]),
            .idx_i  (mem_idx_c),
            .wdata_i(mem_wdata_c),
            .rdata_o(bank_rdata[b])
        );
    end

    // Output mux selects the bank of the most recent accepted read
    assign rdata  = bank_rdata[sel_q];
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bnn_mem_responder.sv
// Self-checking bench: directed plan plus randomized traffic against a behavioural memory model.
module tb_bnn_mem_responder;

    localparam int unsigned ADDR_LEN = 5;
    localparam int unsigned DATA_LEN = 1;
    localparam int unsigned SEL_LEN  = 2;
    localparam int unsigned RW_LEN   = 2;
    localparam int unsigned DEPTH    = 16;
    localparam int          NB       = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [ADDR_LEN-1:0] addr = '0;
    logic [SEL_LEN-1:0]  sel = '0;
    logic [RW_LEN-1:0]   rw = '0;
    logic [DATA_LEN-1:0] wdata = '0;
    logic [DATA_LEN-1:0] rdata;
    logic                rvalid;
    logic                busy;
    logic                err;

    always #5 clk = ~clk;

    bnn_mem_responder #(
        .ADDR_LEN(ADDR_LEN),
        .DATA_LEN(DATA_LEN),
        .SEL_LEN (SEL_LEN),
        .RW_LEN  (RW_LEN),
        .DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .sel   (sel),
        .rw    (rw),
        .wdata (wdata),
        .rdata (rdata),
        .rvalid(rvalid),
        .busy  (busy),
        .err   (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: memory image, remaining busy cycles, expected outputs
    int   m_mem [NB][DEPTH];
    int   busy_left;
    int   e_rdata;
    bit   e_rvalid;
    bit   e_err;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_left = DEPTH;
        e_rdata   = 0;
        e_rvalid  = 1'b0;
        e_err     = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < int'(DEPTH); a++)
                m_mem[b][a] = 0;
    endtask

    // Effect of one command sampled at a clock edge
    task automatic model_step(input int c, input int s, input int a, input int d);
        e_rvalid = 1'b0;
        e_err    = 1'b0;
        if (busy_left > 0) begin
            if (c != 0) e_err = 1'b1;
            busy_left--;
        end else begin
            case (c)
                1: if (a < int'(DEPTH)) begin
                       e_rdata  = m_mem[s][a];
                       e_rvalid = 1'b1;
                   end else e_err = 1'b1;
                2: if (a < int'(DEPTH)) m_mem[s][a] = d;
                   else e_err = 1'b1;
                3: begin
                       for (int i = 0; i < int'(DEPTH); i++) m_mem[s][i] = 0;
                       busy_left = DEPTH;
                   end
                default: ;
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   32'(busy),   32'(busy_left > 0));
            chk("rvalid", 32'(rvalid), 32'(e_rvalid));
            chk("err",    32'(err),    32'(e_err));
            chk("rdata",  32'(rdata),  32'(e_rdata));
        end
    end

    // Apply one command for one cycle; returns at the following falling edge
    task automatic step(input int c, input int s, input int a, input int d);
        rw    = RW_LEN'(c);
        sel   = SEL_LEN'(s);
        addr  = ADDR_LEN'(a);
        wdata = DATA_LEN'(d);
        @(posedge clk);
        model_step(c, s, a, d);
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check reset values at once, release on a falling edge
    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        rw    = '0;
        #1;
        model_reset();
        chk("rst_rdata",  32'(rdata),  32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err",    32'(err),    32'd0);
        chk("rst_busy",   32'(busy),   32'd1);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count cycles until busy drops, with a bounded budget
    task automatic count_busy(input string name, input int c, input bit chk_err);
        int n;
        n = 0;
        while (busy && n < 100) begin
            step(c, 0, 0, 0);
            if (chk_err) begin
                chk({name, "_err"},    32'(err),    32'd1);
                chk({name, "_rvalid"}, 32'(rvalid), 32'd0);
            end
            n++;
        end
        chk({name, "_len"}, 32'(n), 32'd16);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;

        // 1: init length and a post-init read
        do_reset(3);
        count_busy("init", 0, 1'b0);
        step(1, 3, 15, 0);
        chk("t1_rvalid", 32'(rvalid), 32'd1);
        chk("t1_rdata",  32'(rdata),  32'd0);

        // 2: write-then-read coherence and bank isolation
        step(2, 2, 5, 1);
        step(1, 2, 5, 0);
        chk("t2_rdata",  32'(rdata),  32'd1);
        chk("t2_rvalid", 32'(rvalid), 32'd1);
        step(1, 1, 5, 0);
        chk("t2_iso",    32'(rdata),  32'd0);

        // 3: back-to-back reads of an alternating pattern
        for (int i = 0; i < 16; i++) step(2, 0, i, (i % 2 == 0) ? 1 : 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, i, 0);
            chk("t3_rvalid", 32'(rvalid), 32'd1);
            chk("t3_rdata",  32'(rdata),  (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // 4: out-of-range read and write
        step(1, 0, 16, 0);
        chk("t4_rd_err",  32'(err),    32'd1);
        chk("t4_rd_rv",   32'(rvalid), 32'd0);
        chk("t4_rd_hold", 32'(rdata),  32'd0);
        step(2, 0, 20, 0);
        chk("t4_wr_err",  32'(err),    32'd1);
        step(0, 0, 0, 0);
        chk("t4_err_pulse", 32'(err),  32'd0);
        step(1, 0, 0, 0);
        chk("t4_addr0",   32'(rdata),  32'd1);
        step(1, 0, 4, 0);
        chk("t4_addr4",   32'(rdata),  32'd1);

        // 5: clear bank 1, reads during busy rejected, bank 0 intact
        for (int i = 0; i < 16; i++) step(2, 1, i, 1);
        step(3, 1, 31, 0);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_err",  32'(err),  32'd0);
        count_busy("clr", 1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, i, 0);
            chk("t5_b1", 32'(rdata), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            step(1, 0, i, 0);
            chk("t5_b0", 32'(rdata), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // 6: reset in the middle of a clear restarts a full init
        step(3, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        do_reset(2);
        count_busy("reinit", 0, 1'b0);
        step(1, 0, 0, 0);
        chk("t6_cleared", 32'(rdata), 32'd0);

        // Randomized traffic with occasional clears and resets
        for (int k = 0; k < 3000; k++) begin
            int r, c;
            r = int'($urandom_range(0, 99));
            if (r < 20) c = 0;
            else if (r < 60) c = 1;
            else if (r < 96) c = 2;
            else c = 3;
            if ($urandom_range(0, 999) < 3) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 19)),
                     int'($urandom_range(0, 1)));
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_mem_responder.md
Name: bnn_mem_responder

Overview:
Memory-side responder for the compute engine's weight/activation fetch interface (addr/sel/rw/data). It holds 2^SEL_LEN banks of DEPTH words and serves single-word reads and writes issued by the compute FSM. It also runs a self-clear sequence after reset and on a bank-clear command. One instance sits behind the weight port and one behind the x port; parameters select the sizing.

Parameters:
ADDR_LEN, 10, address width; must satisfy 2^ADDR_LEN >= DEPTH.
DATA_LEN, 1, word width (binarised weights/activations).
SEL_LEN, 2, bank-select width; NUM_BANKS = 2^SEL_LEN.
RW_LEN, 2, command width.
DEPTH, 784, words per bank; valid addresses are 0..DEPTH-1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
addr  input  ADDR_LEN  word address.
sel  input  SEL_LEN  bank select.
rw  input  RW_LEN  command: 00 idle, 01 read, 10 write, 11 clear bank.
wdata  input  DATA_LEN  write data.
rdata  output  DATA_LEN  read data; registered.
rvalid  output  1  one-cycle pulse when rdata carries a new read result.
busy  output  1  high while INIT or CLEAR runs; commands are not accepted.
err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset asserted: rdata=0, rvalid=0, err=0, busy=1, state=INIT, clear pointer=0. Array contents are not reset asynchronously.
- States and transitions:
  - INIT: each cycle, write 0 to ptr in every bank, then ptr++. At ptr==DEPTH-1 the next state is IDLE. busy stays 1 for exactly DEPTH cycles after reset release.
  - IDLE: accepts commands. busy=0.
  - CLEAR: entered on rw=11. sel is captured into clr_bank. Writes 0 to clr_bank[ptr] for ptr=0..DEPTH-1 (DEPTH cycles), then returns to IDLE. busy=1 from the cycle after the command until CLEAR exits.
- Read (rw=01, IDLE, addr<DEPTH): rdata=mem[sel][addr] and rvalid=1 at the next edge. Latency is 1. Reads can issue back-to-back, one per cycle.
- Write (rw=10, IDLE, addr<DEPTH): mem[sel][addr]=wdata at the edge. No rvalid is produced. A read of the same address in the following cycle returns the new value (write-then-read is coherent).
- rdata holds its last value when rvalid=0.
- Command 00: no action.
- Out-of-range (addr>=DEPTH on read or write): no array effect, rvalid=0, rdata unchanged, err=1 at the next edge for one cycle.
- Any non-idle command while busy=1: ignored and no array effect; err pulses 1 at the next edge.
- rw=11 in IDLE: addr is ignored and never flags err.
- Reset asserted mid-CLEAR or mid-INIT: the sequence aborts immediately and restarts INIT from ptr=0 after release.
- Widths: ptr is ADDR_LEN bits. The terminal compare uses DEPTH-1, so there is no wrap past DEPTH.

Decomposition:
- Shared package holds:
  - Command constants RW_IDLE=2'b00, RW_READ=2'b01, RW_WRITE=2'b10, RW_CLEAR=2'b11.
  - State encodings ST_INIT, ST_IDLE, ST_CLEAR.
  - Default DEPTH values: 784 for x, 802816/NUM_BANKS for w.
- Sub-module bnn_mem_bank: one DEPTH x DATA_LEN array with a single synchronous write port and a registered read port, instantiated NUM_BANKS times. The top level holds the FSM, command decode, error logic and the output mux.

Test Plan (DEPTH=16, SEL_LEN=2, DATA_LEN=1 unless noted):
1. Release rst_n -> busy=1 for exactly 16 cycles, then 0. A read of bank 3 addr 15 returns rdata=0 with rvalid=1 one cycle after the request.
2. Write 1 to (sel=2, addr=5), then read (2,5) in the next cycle -> rdata=1, rvalid=1 at the edge after the read. A read of (1,5) -> 0, showing bank isolation.
3. Back-to-back reads over addr 0..15 of a bank preloaded with alternating 1/0 -> rvalid high for 16 consecutive cycles, and rdata follows 1,0,1,0,... with 1-cycle latency.
4. Read at addr=16 and write at addr=20 -> err pulses once each, rvalid stays 0, and a subsequent read of addr 0 is unchanged.
5. Fill bank 1 with 1s, issue rw=11 with sel=1 -> busy=1 for 16 cycles, and a read during busy gives err=1 and no rvalid. Afterwards bank 1 reads all 0 while bank 0 contents are intact.
6. Assert rst_n low at cycle 8 of a CLEAR -> outputs return to reset values at once, and INIT runs a full 16 cycles after release.
